// File: rtl/sm2c_pipe_converter_pkg.sv
// ----------------------------------------------------------------------------
// sm2c_pipe_converter_pkg
// Shared definitions for the sign-magnitude / two's-complement converter.
//   MODE_SM2C / MODE_C2SM : per-beat conversion direction encoding
//   sm2c_ovf_pred()       : SM2C overflow predicate for a lane of width n
// ----------------------------------------------------------------------------
package sm2c_pipe_converter_pkg;

   localparam logic MODE_SM2C = 1'b0;
   localparam logic MODE_C2SM = 1'b1;

   // A magnitude fits in n-bit two's complement when it is below 2^(n-1)
   // (positive) or at most 2^(n-1) (negative). The magnitude is passed
   // zero-extended to 32 bits, so n must not exceed 32.
   function automatic logic sm2c_ovf_pred(input logic [31:0] mag,
                                          input logic        sign,
                                          input int          n);
      logic [31:0] half;
      half = 32'd1 << (n - 1);
      return (!sign && ((mag & half) != 32'd0)) || (sign && (mag > half));
   endfunction

endpackage

// File: rtl/sm2c_pipe_converter_lane.sv
// ----------------------------------------------------------------------------
// sm2c_lane
// One lane of the converter: both pipeline stages of the invert / increment
// datapath plus the overflow flag.
//   clk, rst     : clock, synchronous active-high reset
//   s1_load      : capture a new beat into stage 1
//   s2_load      : move stage 1 contents into stage 2
//   mode         : MODE_SM2C or MODE_C2SM for the beat being captured
//   data, sign   : lane input (sign is used in SM2C only)
//   out_data     : registered converted value
//   out_sign     : registered result sign
//   out_ovf      : registered overflow flag (SM2C only)
// Optional macro SM2C_SATURATE_EN: clamp overflowing SM2C results.
// ----------------------------------------------------------------------------
module sm2c_lane
   import sm2c_pipe_converter_pkg::*;
#(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s1_load,
   input  logic         s2_load,
   input  logic         mode,
   input  logic [N-1:0] data,
   input  logic         sign,
   output logic [N-1:0] out_data,
   output logic         out_sign,
   output logic         out_ovf
);

   // Both directions are "negate if the effective sign is set"; only the
   // source of that sign differs.
   logic eff_sign;
   logic ovf_pre;

   always_comb begin
      eff_sign = (mode == MODE_SM2C) ? sign : data[N-1];
      ovf_pre  = (mode == MODE_SM2C) && sm2c_ovf_pred(32'(data), sign, N);
   end

   // Stage 1: conditionally inverted data, the +1 bit, mode, overflow.
   logic [N-1:0] s1_inv_reg;
   logic         s1_inc_reg;
   logic         s1_mode_reg;
   logic         s1_ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_inv_reg  <= '0;
         s1_inc_reg  <= 1'b0;
         s1_mode_reg <= MODE_SM2C;
         s1_ovf_reg  <= 1'b0;
      end else if (s1_load) begin
         s1_inv_reg  <= data ^ {N{eff_sign}};
         s1_inc_reg  <= eff_sign;
         s1_mode_reg <= mode;
         s1_ovf_reg  <= ovf_pre;
      end
   end

   // Stage 2: the sum and the flags.
   logic [N-1:0] sum;
   logic [N-1:0] data_next;
   logic         sign_next;
   logic [N-1:0] data_reg;
   logic         sign_reg;
   logic         ovf_reg;

   always_comb begin
      sum       = s1_inv_reg + N'(s1_inc_reg);
      data_next = sum;
      // SM2C reports the MSB of the result; C2SM reports the extracted sign.
      sign_next = (s1_mode_reg == MODE_SM2C) ? sum[N-1] : s1_inc_reg;
`ifdef SM2C_SATURATE_EN
      // The overflow flag only ever sets in SM2C, where s1_inc_reg is the
      // input sign and so selects the clamp direction.
      if (s1_ovf_reg) begin
         data_next = s1_inc_reg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
         sign_next = s1_inc_reg;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
         sign_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (s2_load) begin
         data_reg <= data_next;
         sign_reg <= sign_next;
         ovf_reg  <= s1_ovf_reg;
      end
   end

   assign out_data = data_reg;
   assign out_sign = sign_reg;
   assign out_ovf  = ovf_reg;

endmodule

// File: rtl/sm2c_pipe_converter.sv
// ----------------------------------------------------------------------------
// sm2c_pipe_converter
// Multi-lane two-stage pipelined converter between sign-magnitude and two's
// complement with valid/ready flow control and a saturating overflow counter.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   mode                 : 0 = SM2C, 1 = C2SM, sampled with the beat
//   in_data, in_sign     : CH lanes of N bits, lane i at [i*N +: N]
//   out_valid / out_ready: output handshake
//   out_data, out_sign, out_ovf : converted lanes and per-lane flags
//   ovf_cnt, ovf_clr     : transferred beats with any overflow, and its clear
// Optional macro SM2C_SATURATE_EN: clamp overflowing SM2C lanes.
// ----------------------------------------------------------------------------
module sm2c_pipe_converter
   import sm2c_pipe_converter_pkg::*;
#(
   parameter int N     = 5,
   parameter int CH    = 2,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            mode,
   input  logic [CH*N-1:0] in_data,
   input  logic [CH-1:0]   in_sign,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CH*N-1:0] out_data,
   output logic [CH-1:0]   out_sign,
   output logic [CH-1:0]   out_ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic            ovf_clr
);

   logic s1_valid_reg;
   logic s2_valid_reg;
   logic adv1;
   logic adv2;
   logic s1_load;
   logic s2_load;

   // A stage may advance when it is empty or the stage after it advances,
   // so a full pipe keeps streaming as long as out_ready stays high.
   always_comb begin
      adv2    = !s2_valid_reg || out_ready;
      adv1    = !s1_valid_reg || adv2;
      s1_load = adv1 && in_valid;
      s2_load = adv2 && s1_valid_reg;
   end

   assign in_ready  = adv1;
   assign out_valid = s2_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (adv1) s1_valid_reg <= in_valid;
         if (adv2) s2_valid_reg <= s1_valid_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_lane
         sm2c_lane #(.N(N)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_load  (s1_load),
            .s2_load  (s2_load),
            .mode     (mode),
            .data     (in_data[gi*N +: N]),
            .sign     (in_sign[gi]),
            .out_data (out_data[gi*N +: N]),
            .out_sign (out_sign[gi]),
            .out_ovf  (out_ovf[gi])
         );
      end
   endgenerate

   // Saturating count of transferred beats carrying any overflow; the clear
   // wins over a same-cycle increment.
   logic [CNT_W-1:0] ovf_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || ovf_clr) begin
         ovf_cnt_reg <= '0;
      end else if (out_valid && out_ready && (|out_ovf) && (ovf_cnt_reg != {CNT_W{1'b1}})) begin
         ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      end
   end

   assign ovf_cnt = ovf_cnt_reg;

endmodule

// File: tb/tb_sm2c_pipe_converter.sv
// ----------------------------------------------------------------------------
// tb_sm2c_pipe_converter
// Scoreboard bench for sm2c_pipe_converter (N=5, CH=2, CNT_W=8). Accepted
// beats push their hand-computed expected output into a queue; a monitor
// pops and compares on every output transfer.
// ----------------------------------------------------------------------------
module tb_sm2c_pipe_converter;

   localparam int N     = 5;
   localparam int CH    = 2;
   localparam int CNT_W = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            mode = 1'b0;
   logic [CH*N-1:0] in_data = '0;
   logic [CH-1:0]   in_sign = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [CH*N-1:0] out_data;
   logic [CH-1:0]   out_sign;
   logic [CH-1:0]   out_ovf;
   logic [CNT_W-1:0] ovf_cnt;
   logic            ovf_clr = 1'b0;

   sm2c_pipe_converter #(.N(N), .CH(CH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .in_data   (in_data),
      .in_sign   (in_sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sign  (out_sign),
      .out_ovf   (out_ovf),
      .ovf_cnt   (ovf_cnt),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            mode;
      logic [CH*N-1:0] data;
      logic [CH-1:0]   sign;
      logic [CH*N-1:0] exp_data;
      logic [CH-1:0]   exp_sign;
      logic [CH-1:0]   exp_ovf;
   } vec_t;

   typedef struct packed {
      logic [CH*N-1:0] data;
      logic [CH-1:0]   sign;
      logic [CH-1:0]   ovf;
   } exp_t;

   // Lanes written {lane1, lane0}.
   vec_t vecs [13];
   exp_t sb_q [$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   initial begin
      // 0: SM2C a0=5 s=1, a1=3 s=0
      vecs[0]  = '{1'b0, {5'b00011, 5'b00101}, 2'b01, {5'b00011, 5'b11011}, 2'b01, 2'b00};
`ifdef SM2C_SATURATE_EN
      // 1: a0=16 s=1 fits; a1=16 s=0 positive overflow -> clamp 01111
      vecs[1]  = '{1'b0, {5'b10000, 5'b10000}, 2'b01, {5'b01111, 5'b10000}, 2'b01, 2'b10};
      // 2: a0=0 s=1 -> 0; a1=17 s=1 negative overflow -> clamp 10000
      vecs[2]  = '{1'b0, {5'b10001, 5'b00000}, 2'b11, {5'b10000, 5'b00000}, 2'b10, 2'b10};
`else
      vecs[1]  = '{1'b0, {5'b10000, 5'b10000}, 2'b01, {5'b10000, 5'b10000}, 2'b11, 2'b10};
      vecs[2]  = '{1'b0, {5'b10001, 5'b00000}, 2'b11, {5'b01111, 5'b00000}, 2'b00, 2'b10};
`endif
      // 3: C2SM v0=11011 -> 00101 s1; v1=10000 -> 10000 s1 (in_sign ignored)
      vecs[3]  = '{1'b1, {5'b10000, 5'b11011}, 2'b10, {5'b10000, 5'b00101}, 2'b11, 2'b00};
      // 4: C2SM v0=00111 -> 00111 s0; v1=11111 -> 00001 s1
      vecs[4]  = '{1'b1, {5'b11111, 5'b00111}, 2'b11, {5'b00001, 5'b00111}, 2'b10, 2'b00};
      // 5..8: backpressure stream
      vecs[5]  = '{1'b0, {5'b00010, 5'b00001}, 2'b01, {5'b00010, 5'b11111}, 2'b01, 2'b00};
      vecs[6]  = '{1'b0, {5'b01111, 5'b01111}, 2'b10, {5'b10001, 5'b01111}, 2'b10, 2'b00};
      vecs[7]  = '{1'b1, {5'b11110, 5'b00001}, 2'b00, {5'b00010, 5'b00001}, 2'b10, 2'b00};
      vecs[8]  = '{1'b0, {5'b00000, 5'b00111}, 2'b01, {5'b00000, 5'b11001}, 2'b01, 2'b00};
      // 9..12: alternating mode, identical data for 9/10
      vecs[9]  = '{1'b0, {5'b00011, 5'b00101}, 2'b11, {5'b11101, 5'b11011}, 2'b11, 2'b00};
      vecs[10] = '{1'b1, {5'b00011, 5'b00101}, 2'b11, {5'b00011, 5'b00101}, 2'b00, 2'b00};
      vecs[11] = '{1'b0, {5'b00001, 5'b01000}, 2'b01, {5'b00001, 5'b11000}, 2'b01, 2'b00};
      vecs[12] = '{1'b1, {5'b01000, 5'b11000}, 2'b00, {5'b01000, 5'b01000}, 2'b01, 2'b00};
   end

   // Present one beat, wait (bounded) for acceptance, log its expectation.
   task automatic send(input int idx);
      bit ok;
      in_valid = 1'b1;
      mode     = vecs[idx].mode;
      in_data  = vecs[idx].data;
      in_sign  = vecs[idx].sign;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else sb_q.push_back('{vecs[idx].exp_data, vecs[idx].exp_sign, vecs[idx].exp_ovf});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on transfers, and check held output stays put while stalled.
   logic            stall_prev = 1'b0;
   logic [CH*N-1:0] stall_data;
   int              beat_no = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (stall_prev) begin
               chk("stall_valid_held", 32'(out_valid), 32'd1);
               chk("stall_data_held", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_beat", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("out_sign", 32'(out_sign), 32'(e.sign));
                  chk("out_ovf",  32'(out_ovf),  32'(e.ovf));
                  $display("beat %0d: data=%b sign=%b ovf=%b cnt=%0d", beat_no, out_data, out_sign, out_ovf, ovf_cnt);
                  beat_no++;
               end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data), 32'd0);
      chk("rst_out_sign",  32'(out_sign), 32'd0);
      chk("rst_out_ovf",   32'(out_ovf), 32'd0);
      chk("rst_ovf_cnt",   32'(ovf_cnt), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Latency: accept at one edge, out_valid visible after the second edge.
      send(0);
      chk("lat_cycle1_invalid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      drain();

      // Boundaries and counter
      send(1);
      drain();
      chk("ovf_cnt_after_1", 32'(ovf_cnt), 32'd1);
      send(2);
      drain();
      chk("ovf_cnt_after_2", 32'(ovf_cnt), 32'd2);

      // C2SM
      send(3);
      send(4);
      drain();

      // Backpressure: 4 beats, out_ready low for 3 edges mid-stream
      fork
         begin
            for (int i = 5; i <= 8; i++) send(i);
         end
         begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Alternating mode at full throughput
      for (int i = 9; i <= 12; i++) send(i);
      drain();
      chk("ovf_cnt_no_change", 32'(ovf_cnt), 32'd2);

      // Saturation of the counter
      for (int i = 0; i < 260; i++) send(1);
      drain();
      chk("ovf_cnt_saturated", 32'(ovf_cnt), 32'd255);

      // Clear coincident with an overflowing transfer
      send(1);
      begin
         bit ok;
         ok = 1'b0;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) chk("clr_wait_timeout", 32'd0, 32'd1);
      end
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      chk("ovf_cnt_clr_priority", 32'(ovf_cnt), 32'd0);
      drain();

      // Reset mid-stream
      send(1);
      drain();
      chk("ovf_cnt_pre_rst", 32'(ovf_cnt), 32'd1);
      send(0);
      send(3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb_q.delete();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);
      send(0);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
